// File: rtl/traffic_pkg.sv
// Shared definitions for the traffic phase controller: phase encoding,
// per-approach lamp patterns and the density popcount helper.
package traffic_pkg;

  typedef enum logic [2:0] {
    ST_CLEAR   = 3'd0,
    ST_GREEN   = 3'd1,
    ST_YELLOW  = 3'd2,
    ST_PGREEN  = 3'd3,
    ST_PYELLOW = 3'd4
  } phase_e;

  // Lamp order within an approach is {R,Y,G}.
  localparam logic [2:0] LAMP_R = 3'b100;
  localparam logic [2:0] LAMP_Y = 3'b010;
  localparam logic [2:0] LAMP_G = 3'b001;

  function automatic logic [1:0] popcount3(input logic [2:0] d);
    return 2'(d[0]) + 2'(d[1]) + 2'(d[2]);
  endfunction

endpackage

// File: rtl/traffic_phase_ctrl_if.sv
// Sensor and lamp bundle between the intersection environment (master) and
// the phase controller (slave).
interface traffic_phase_ctrl_if #(
  parameter int N_APPR = 4,
  parameter int IDX_W  = $clog2(N_APPR)
) ();

  // No handshake: inputs are level signals sampled on every rising clock
  // edge, outputs are registered and valid every cycle after reset.
  logic [3*N_APPR-1:0] density;
  logic [N_APPR-1:0]   preempt;
  logic [3*N_APPR-1:0] ID;
  logic [2:0]          state;
  logic [IDX_W-1:0]    active;
  logic [1:0]          level;
  logic                preempt_active;

  modport master (
    output density, preempt,
    input  ID, state, active, level, preempt_active
  );

  modport slave (
    input  density, preempt,
    output ID, state, active, level, preempt_active
  );

endinterface

// File: rtl/rr_demand_pick.sv
// Combinational round-robin search: first approach with demand at or after
// start_i, wrapping, so the approach just before start_i is examined last.
module rr_demand_pick #(
  parameter int N     = 4,
  parameter int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     demand_i,
  input  logic [IDX_W-1:0] start_i,
  output logic             valid_o,
  output logic [IDX_W-1:0] idx_o
);

  always_comb begin
    valid_o = 1'b0;
    idx_o   = start_i;
    // Walk offsets from far to near so the nearest hit overwrites the rest.
    for (int k = N - 1; k >= 0; k--) begin
      if (demand_i[(int'(start_i) + k) % N]) begin
        valid_o = 1'b1;
        idx_o   = IDX_W'((int'(start_i) + k) % N);
      end
    end
  end

endmodule

// File: rtl/traffic_phase_ctrl.sv
// Density-aware round-robin traffic phase controller with emergency preempt,
// fixed yellow and all-red clearance, and registered per-approach lamps.
module traffic_phase_ctrl
  import traffic_pkg::*;
#(
  parameter int N_APPR   = 4,
  parameter int IDX_W    = $clog2(N_APPR),
  parameter int CNT_W    = 6,
  parameter int T_MIN    = 4,
  parameter int T_STEP   = 4,
  parameter int T_YEL    = 3,
  parameter int T_ALLRED = 2
) (
  input logic                  clock,
  input logic                  clear,
  traffic_phase_ctrl_if.slave  bus
);

  if (T_MIN + 3 * T_STEP > (1 << CNT_W)) begin : g_cnt_chk
    $error("traffic_phase_ctrl: T_MIN+3*T_STEP does not fit in CNT_W bits");
  end

  localparam logic [CNT_W-1:0] YEL_LOAD    = CNT_W'(T_YEL - 1);
  localparam logic [CNT_W-1:0] ALLRED_LOAD = CNT_W'(T_ALLRED - 1);
  localparam logic [CNT_W-1:0] PMIN_LOAD   = CNT_W'(T_MIN - 1);

  phase_e              state_q, state_d;
  logic [CNT_W-1:0]    timer_q, timer_d;
  logic [IDX_W-1:0]    active_q, active_d;
  logic [1:0]          level_q, level_d;
  logic                pa_q, pa_d;
  logic [3*N_APPR-1:0] lamp_q, lamp_d;

  logic [N_APPR-1:0]   demand;
  logic [IDX_W-1:0]    start_idx;
  logic                pick_valid;
  logic [IDX_W-1:0]    pick_idx;
  logic [2:0]          pick_dens;
  logic [1:0]          pick_level;
  logic [CNT_W-1:0]    green_load;
  logic [CNT_W-1:0]    timer_dec;
  logic [IDX_W-1:0]    pre_idx;
  logic                pre_any;
  logic                pre_on_active;

  always_comb begin
    demand    = '0;
    pick_dens = '0;
    pre_idx   = '0;
    for (int i = 0; i < N_APPR; i++) begin
      demand[i] = |bus.density[3*i +: 3];
      if (IDX_W'(i) == pick_idx) pick_dens = bus.density[3*i +: 3];
    end
    // Lowest-index preempt request wins.
    for (int i = N_APPR - 1; i >= 0; i--) begin
      if (bus.preempt[i]) pre_idx = IDX_W'(i);
    end
  end

  assign start_idx     = (active_q == IDX_W'(N_APPR - 1)) ? '0 : active_q + IDX_W'(1);
  assign pre_any       = |bus.preempt;
  assign pre_on_active = bus.preempt[active_q];
  assign pick_level    = popcount3(pick_dens);
  assign green_load    = CNT_W'(T_MIN) + CNT_W'(T_STEP) * CNT_W'(pick_level) - CNT_W'(1);
  assign timer_dec     = (timer_q == '0) ? '0 : timer_q - CNT_W'(1);

  rr_demand_pick #(
    .N     (N_APPR),
    .IDX_W (IDX_W)
  ) u_pick (
    .demand_i (demand),
    .start_i  (start_idx),
    .valid_o  (pick_valid),
    .idx_o    (pick_idx)
  );

  always_comb begin
    state_d  = state_q;
    timer_d  = timer_dec;
    active_d = active_q;
    level_d  = level_q;
    pa_d     = pa_q;
    case (state_q)
      ST_CLEAR: begin
        if (timer_q == '0) begin
          if (pre_any) begin
            state_d  = ST_PGREEN;
            active_d = pre_idx;
            pa_d     = 1'b1;
            timer_d  = PMIN_LOAD;
          end else if (pick_valid) begin
            state_d  = ST_GREEN;
            active_d = pick_idx;
            level_d  = pick_level;
            timer_d  = green_load;
          end
        end
      end
      ST_GREEN: begin
        // Preempt on the served approach keeps the running green timer as its
        // minimum dwell instead of passing through yellow.
        if (pre_on_active) begin
          state_d = ST_PGREEN;
          pa_d    = 1'b1;
        end else if (pre_any || timer_q == '0) begin
          state_d = ST_YELLOW;
          timer_d = YEL_LOAD;
        end
      end
      ST_YELLOW: begin
        if (timer_q == '0) begin
          state_d = ST_CLEAR;
          timer_d = ALLRED_LOAD;
        end
      end
      ST_PGREEN: begin
        if (!pre_on_active && timer_q == '0) begin
          state_d = ST_PYELLOW;
          timer_d = YEL_LOAD;
        end
      end
      ST_PYELLOW: begin
        if (timer_q == '0) begin
          state_d = ST_CLEAR;
          pa_d    = 1'b0;
          timer_d = ALLRED_LOAD;
        end
      end
      default: begin
        state_d = ST_CLEAR;
        timer_d = ALLRED_LOAD;
      end
    endcase
  end

  // Lamps are derived from the next phase so they register alongside it.
  always_comb begin
    lamp_d = '0;
    for (int i = 0; i < N_APPR; i++) begin
      lamp_d[3*i +: 3] = LAMP_R;
      if (IDX_W'(i) == active_d) begin
        if (state_d == ST_GREEN || state_d == ST_PGREEN) lamp_d[3*i +: 3] = LAMP_G;
        else if (state_d == ST_YELLOW || state_d == ST_PYELLOW) lamp_d[3*i +: 3] = LAMP_Y;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (clear) begin
      state_q  <= ST_CLEAR;
      timer_q  <= ALLRED_LOAD;
      active_q <= IDX_W'(N_APPR - 1);
      level_q  <= '0;
      pa_q     <= 1'b0;
      lamp_q   <= {N_APPR{LAMP_R}};
    end else begin
      state_q  <= state_d;
      timer_q  <= timer_d;
      active_q <= active_d;
      level_q  <= level_d;
      pa_q     <= pa_d;
      lamp_q   <= lamp_d;
    end
  end

  assign bus.ID             = lamp_q;
  assign bus.state          = state_q;
  assign bus.active         = active_q;
  assign bus.level          = level_q;
  assign bus.preempt_active = pa_q;

endmodule

// File: tb/tb_traffic_phase_ctrl.sv
// Bench for traffic_phase_ctrl: directed scenarios plus randomized traffic,
// every cycle compared against a phase/age reference model.
module tb_traffic_phase_ctrl;

  localparam int N        = 4;
  localparam int IDX_W    = 2;
  localparam int CNT_W    = 6;
  localparam int T_MIN    = 4;
  localparam int T_STEP   = 4;
  localparam int T_YEL    = 3;
  localparam int T_ALLRED = 2;

  logic clock = 1'b0;
  logic clear = 1'b1;
  int   total = 0;
  int   bad   = 0;

  traffic_phase_ctrl_if #(.N_APPR(N), .IDX_W(IDX_W)) bus ();

  traffic_phase_ctrl #(
    .N_APPR(N), .IDX_W(IDX_W), .CNT_W(CNT_W), .T_MIN(T_MIN),
    .T_STEP(T_STEP), .T_YEL(T_YEL), .T_ALLRED(T_ALLRED)
  ) dut (
    .clock (clock),
    .clear (clear),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  // Reference model: phase code, cycles shown so far, phase length.
  int m_ph, m_age, m_dur, m_act, m_lvl, m_pa;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_step();
    logic [N-1:0]   p;
    logic [3*N-1:0] d;
    int base, j;
    bit found;
    p = bus.preempt;
    d = bus.density;
    if (clear) begin
      m_ph = 0; m_age = 1; m_dur = T_ALLRED; m_act = N - 1; m_lvl = 0; m_pa = 0;
      return;
    end
    m_age++;
    case (m_ph)
      0: if (m_age - 1 >= m_dur) begin
        if (p != 0) begin
          for (int i = N - 1; i >= 0; i--) if (p[i]) m_act = i;
          m_ph = 3; m_pa = 1; m_dur = T_MIN; m_age = 1;
        end else begin
          found = 0;
          base  = m_act;
          for (int k = 1; k <= N; k++) begin
            j = (base + k) % N;
            if (!found && d[3*j +: 3] != 3'b000) begin
              found = 1;
              m_act = j;
              m_lvl = $countones(d[3*j +: 3]);
            end
          end
          if (found) begin
            m_ph = 1; m_dur = T_MIN + T_STEP * m_lvl; m_age = 1;
          end
        end
      end
      1: if (p[m_act]) begin
        m_ph = 3; m_pa = 1;
      end else if (p != 0 || m_age - 1 >= m_dur) begin
        m_ph = 2; m_dur = T_YEL; m_age = 1;
      end
      2: if (m_age - 1 >= m_dur) begin
        m_ph = 0; m_dur = T_ALLRED; m_age = 1;
      end
      3: if (!p[m_act] && m_age - 1 >= m_dur) begin
        m_ph = 4; m_dur = T_YEL; m_age = 1;
      end
      4: if (m_age - 1 >= m_dur) begin
        m_ph = 0; m_pa = 0; m_dur = T_ALLRED; m_age = 1;
      end
      default: ;
    endcase
  endtask

  function automatic logic [3*N-1:0] model_lamps();
    logic [3*N-1:0] v;
    for (int i = 0; i < N; i++) begin
      v[3*i +: 3] = 3'b100;
      if (i == m_act && (m_ph == 1 || m_ph == 3)) v[3*i +: 3] = 3'b001;
      if (i == m_act && (m_ph == 2 || m_ph == 4)) v[3*i +: 3] = 3'b010;
    end
    return v;
  endfunction

  task automatic tick();
    @(posedge clock);
    model_step();
    #1;
    check("state", 32'(bus.state), 32'(m_ph));
    check("active", 32'(bus.active), 32'(m_act));
    check("level", 32'(bus.level), 32'(m_lvl));
    check("preempt_active", 32'(bus.preempt_active), 32'(m_pa));
    check("lamps", 32'(bus.ID), 32'(model_lamps()));
  endtask

  task automatic wait_state(input int target, input int max_cyc);
    int n;
    n = 0;
    while (32'(bus.state) != 32'(target) && n < max_cyc) begin
      tick();
      n++;
    end
    check("wait_state", 32'(bus.state), 32'(target));
  endtask

  task automatic measure(input int phase, output int n);
    n = 0;
    while (32'(bus.state) == 32'(phase) && n < 60) begin
      n++;
      tick();
    end
  endtask

  function automatic logic [3*N-1:0] rand_density();
    logic [3*N-1:0] v;
    for (int i = 0; i < N; i++)
      v[3*i +: 3] = ($urandom_range(0, 1) == 0) ? 3'b000 : 3'($urandom_range(1, 7));
    return v;
  endfunction

  initial begin
    int n, hold;
    m_ph = 0; m_age = 1; m_dur = T_ALLRED; m_act = N - 1; m_lvl = 0; m_pa = 0;
    bus.density = '0;
    bus.preempt = '0;

    // Reset, then rest in all-red with no demand.
    clear = 1'b1;
    tick(); tick();
    check("reset_lamps", 32'(bus.ID), 32'h924);
    check("reset_active", 32'(bus.active), 32'd3);
    clear = 1'b0;
    repeat (12) tick();
    check("idle_state", 32'(bus.state), 32'd0);
    check("idle_lamps", 32'(bus.ID), 32'h924);

    // Single approach 1 with two density bits.
    bus.density = 12'h018;
    wait_state(1, 10);
    check("a1_active", 32'(bus.active), 32'd1);
    measure(1, n);
    check("a1_green_len", 32'(n), 32'd12);
    measure(2, n);
    check("a1_yellow_len", 32'(n), 32'd3);
    measure(0, n);
    check("a1_allred_len", 32'(n), 32'd2);
    check("a1_regreen", 32'(bus.state), 32'd1);
    check("a1_level", 32'(bus.level), 32'd2);

    // Approaches 0 and 2 alternate.
    bus.density = 12'h1C1;
    repeat (90) tick();

    // Approach 0 green, preempt on approach 2 for 8 cycles.
    clear = 1'b1; tick(); clear = 1'b0;
    bus.density = 12'h001;
    wait_state(1, 10);
    check("p2_green_a0", 32'(bus.active), 32'd0);
    bus.preempt = 4'b0100;
    tick();
    check("p2_yellow", 32'(bus.state), 32'd2);
    repeat (7) tick();
    bus.preempt = 4'b0000;
    check("p2_pgreen", 32'(bus.state), 32'd3);
    check("p2_pactive", 32'(bus.active), 32'd2);
    repeat (40) tick();

    // Preempt on the approach already green.
    clear = 1'b1; tick(); clear = 1'b0;
    wait_state(1, 10);
    bus.preempt = 4'b0001;
    tick();
    check("self_pgreen", 32'(bus.state), 32'd3);
    check("self_pa", 32'(bus.preempt_active), 32'd1);
    repeat (6) tick();
    bus.preempt = 4'b0000;
    repeat (30) tick();

    // Two simultaneous preempts: lower index first.
    bus.preempt = 4'b1010;
    repeat (25) tick();
    bus.preempt = 4'b0000;
    repeat (25) tick();

    // Reset in the middle of yellow.
    bus.density = 12'h208;
    wait_state(2, 60);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    check("mid_clear_lamps", 32'(bus.ID), 32'h924);
    check("mid_clear_active", 32'(bus.active), 32'd3);
    wait_state(1, 10);
    check("post_clear_pick", 32'(bus.active), 32'd1);

    // Randomized traffic.
    hold = 0;
    for (int c = 0; c < 2000; c++) begin
      if ($urandom_range(0, 15) == 0) bus.density = rand_density();
      if (hold > 0) begin
        hold--;
        if (hold == 0) bus.preempt = '0;
      end else if ($urandom_range(0, 39) == 0) begin
        bus.preempt = N'(1 << $urandom_range(0, N - 1));
        if ($urandom_range(0, 3) == 0) bus.preempt = bus.preempt | N'(1 << $urandom_range(0, N - 1));
        hold = $urandom_range(1, 20);
      end
      clear = ($urandom_range(0, 199) == 0);
      tick();
    end
    clear = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
